// File: rtl/burst_sync_pkg.sv
// Shared definitions for the burst sequencer: FSM encoding, trigger field positions and defaults.
package burst_sync_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    // Nominal trigger-to-long-preamble distance; software loads the real value into skip_len.
    localparam int unsigned SKIP_DEF  = 32;

    localparam int unsigned TRIG_OFFSET_MSB = 31;
    localparam int unsigned TRIG_OFFSET_LSB = 16;
    localparam int unsigned TRIG_PHASE_MSB  = 15;
    localparam int unsigned TRIG_PHASE_LSB  = 0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SKIP    = 2'd1,
        S_PASS    = 2'd2,
        S_HOLDOFF = 2'd3
    } state_e;

endpackage

// File: rtl/axi_fifo_flop.sv
// Single-entry AXI-Stream register slice; sustains full throughput while the sink is ready.
module axi_fifo_flop #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign i_tready = !valid_q || o_tready;
    assign o_tvalid = valid_q;
    assign o_tdata  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_tready) begin
            valid_d = i_tvalid;
            if (i_tvalid) begin
                data_d = i_tdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/burst_sync_ctrl.sv
// Burst sequencer: on a plateau trigger, skips to the long preamble, forwards one burst with
// tlast, latches the CFO phase and holds eof to the detector for a holdoff period.
module burst_sync_ctrl
    import burst_sync_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] skip_len,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CNT_W-1:0] holdoff_len,
    input  logic [31:0]      trig_tdata,
    input  logic             trig_tlast,
    input  logic             trig_tvalid,
    output logic             trig_tready,
    input  logic [31:0]      i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [31:0]      o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [15:0]      cfo_phase,
    output logic             cfo_valid,
    output logic             eof,
    output logic             busy,
    output logic [15:0]      burst_cnt,
    output logic [15:0]      overrun_cnt
);

    localparam int unsigned CMP_W = (CNT_W > 16) ? CNT_W : 16;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] burst_len_q, burst_len_d;
    logic [CNT_W-1:0] holdoff_len_q, holdoff_len_d;
    logic [15:0]      cfo_phase_q, cfo_phase_d;
    logic             cfo_valid_q, cfo_valid_d;
    logic             eof_q, eof_d;
    logic [15:0]      burst_cnt_q, burst_cnt_d;
    logic [15:0]      overrun_cnt_q, overrun_cnt_d;

    logic             stage_in_ready, stage_ready, stage_in_valid, xfer, last_beat;
    logic [32:0]      stage_in_data, stage_out_data;
    logic [CMP_W-1:0] skip_ext, offset_ext, skip_eff;

    // Discarded beats never wait on the output stage.
    assign stage_ready    = (state_q == S_PASS) ? stage_in_ready : 1'b1;
    assign xfer           = trig_tvalid && i_tvalid && stage_ready;
    assign trig_tready    = xfer;
    assign i_tready       = xfer;
    assign last_beat      = (cnt_q == CNT_W'(1));
    assign stage_in_valid = xfer && (state_q == S_PASS);
    assign stage_in_data  = {last_beat, i_tdata};

    assign skip_ext   = CMP_W'(skip_len);
    assign offset_ext = CMP_W'(trig_tdata[TRIG_OFFSET_MSB:TRIG_OFFSET_LSB]);
    assign skip_eff   = (skip_ext > offset_ext) ? (skip_ext - offset_ext) : '0;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        burst_len_d   = burst_len_q;
        holdoff_len_d = holdoff_len_q;
        cfo_phase_d   = cfo_phase_q;
        cfo_valid_d   = 1'b0;
        burst_cnt_d   = burst_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        if (xfer) begin
            if (trig_tlast && (state_q != S_IDLE) && (overrun_cnt_q != 16'hFFFF)) begin
                overrun_cnt_d = overrun_cnt_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (trig_tlast) begin
                        burst_len_d   = burst_len;
                        holdoff_len_d = holdoff_len;
                        cfo_valid_d   = 1'b1;
                        cfo_phase_d   = trig_tdata[TRIG_PHASE_MSB:TRIG_PHASE_LSB];
                        if (skip_eff != '0) begin
                            state_d = S_SKIP;
                            cnt_d   = CNT_W'(skip_eff);
                        end else if (burst_len != '0) begin
                            state_d = S_PASS;
                            cnt_d   = burst_len;
                        end else if (holdoff_len != '0) begin
                            state_d = S_HOLDOFF;
                            cnt_d   = holdoff_len;
                        end
                    end
                end
                S_SKIP: begin
                    if (last_beat) begin
                        if (burst_len_q != '0) begin
                            state_d = S_PASS;
                            cnt_d   = burst_len_q;
                        end else if (holdoff_len_q != '0) begin
                            state_d = S_HOLDOFF;
                            cnt_d   = holdoff_len_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_PASS: begin
                    if (last_beat) begin
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        if (holdoff_len_q != '0) begin
                            state_d = S_HOLDOFF;
                            cnt_d   = holdoff_len_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        eof_d = (state_d == S_HOLDOFF);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            burst_len_q   <= '0;
            holdoff_len_q <= '0;
            cfo_phase_q   <= '0;
            cfo_valid_q   <= 1'b0;
            eof_q         <= 1'b0;
            burst_cnt_q   <= '0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            burst_len_q   <= burst_len_d;
            holdoff_len_q <= holdoff_len_d;
            cfo_phase_q   <= cfo_phase_d;
            cfo_valid_q   <= cfo_valid_d;
            eof_q         <= eof_d;
            burst_cnt_q   <= burst_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    axi_fifo_flop #(
        .WIDTH(33)
    ) u_out_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .i_tdata (stage_in_data),
        .i_tvalid(stage_in_valid),
        .i_tready(stage_in_ready),
        .o_tdata (stage_out_data),
        .o_tvalid(o_tvalid),
        .o_tready(o_tready)
    );

    assign o_tdata     = stage_out_data[31:0];
    assign o_tlast     = stage_out_data[32];
    assign cfo_phase   = cfo_phase_q;
    assign cfo_valid   = cfo_valid_q;
    assign eof         = eof_q;
    assign busy        = (state_q != S_IDLE);
    assign burst_cnt   = burst_cnt_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule
